mult12_accum: RTL and testbench
===============================

# mult12_accum

Downstream accumulation stage for the 12x12 unsigned array multiplier. It consumes the multiplier's 24-bit product one beat per cycle over a valid/ready handshake and sums a frame of up to MAX_LEN products into an ACC_W-bit accumulator. It then presents the frame total, the beat count and an overflow flag on a held output handshake. The multiplier itself stays purely combinational; this block supplies the first register stage behind it.

## Interface
- PROD_W, 24, product width; must equal 2x multiplier operand width
- ACC_W, 32, accumulator width; must be >= PROD_W
- MAX_LEN, 16, maximum beats per frame; a frame auto-closes when this count is reached
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  product beat offered
- in_ready  out  1  block accepts a beat this cycle
- in_prod  in  PROD_W  unsigned product from the multiplier output
- in_last  in  1  beat closes the current frame
- out_valid  out  1  frame result presented
- out_ready  in  1  consumer takes the result
- out_sum  out  ACC_W  frame sum, modulo 2^ACC_W
- out_count  out  $clog2(MAX_LEN+1)  beats in the frame (1..MAX_LEN)
- out_ovf  out  1  a carry out of bit ACC_W-1 occurred during the frame

## Operation
- Beat accepted when in_valid && in_ready. in_prod is zero-extended to ACC_W+1 bits and added to the accumulator. The carry bit ORs into a sticky ovf. The sum wraps modulo 2^ACC_W.
- States:
  - IDLE: no open frame; acc=0, count=0.
  - ACC: frame open, count >= 1.
  - HOLD: result registered, out_valid=1.
- IDLE/ACC:
  - in_ready=1.
  - An accepted beat with in_last=1, or one making count==MAX_LEN, loads the final sum, count and ovf into the output registers and moves to HOLD.
  - Any other accepted beat goes to ACC.
- HOLD:
  - in_ready = out_ready, combinational.
  - out_sum, out_count and out_ovf are stable until the handshake.
  - On out_ready with no beat: go to IDLE, clear acc, count and ovf.
  - On out_ready with a simultaneous beat: that beat starts the next frame (acc=in_prod, count=1, ovf=0) and goes to ACC. If the beat also closes its frame (in_last=1 or MAX_LEN=1), go directly back to HOLD with the new result.
- in_last on a beat that is not accepted has no effect.
- in_prod, in_last and out_ready values are ignored when not part of a handshake.

## Timing
- Reset:
  - rst_n low at an edge forces IDLE.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, acc=0, count=0.
  - in_ready=1 from the first cycle after reset.
  - A partially accumulated frame is discarded; no output is produced for it.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Throughput: one beat per cycle. The only bubble is when the consumer stalls in HOLD.
- All outputs are registered except in_ready, which depends combinationally on the state and on out_ready.
- The combinational multiplier-to-accumulator path is one cycle. The 24-bit multiplier tree plus an ACC_W adder must close timing within one period.

## Structure
- Shared package mult_pkg holds:
  - PROD_W and the operand width constant (12).
  - The state enum {IDLE, ACC, HOLD}.
- No sub-module. The adder is an inline ACC_W+1-bit add, and the FSM lives in the same module.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release -> out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
- Basic frame: three beats of 0xFFE001 (0xFFF*0xFFF), in_last on the third -> next cycle out_valid=1, out_sum=0x2FFA003, out_count=3, out_ovf=0.
- Auto-close: 16 beats of value 1, in_last never asserted -> out_sum=16, out_count=16; the 17th beat is not accepted until out_ready.
- Backpressure and overlap:
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and the outputs stay stable.
  - Then out_ready=1 with beat 7 -> both handshakes complete in the same cycle, and the next frame starts with acc=7, count=1.
- Overflow: with ACC_W=26, five beats of 0xFFE001 -> out_sum=16736261, out_ovf=1; the following frame reports out_ovf=0.
- Reset mid-frame: accept two beats, then assert rst_n low for one cycle -> all state is cleared, out_valid never asserts for that frame, and a new single last beat of 5 gives out_sum=5, out_count=1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the 12x12 multiplier and its accumulation stage.
package mult_pkg;

    localparam int OP_W   = 12;
    localparam int PROD_W = 2 * OP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mult12_accum_if.sv
// Product-in / frame-result-out bus of the accumulation stage.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The sender keeps valid and its payload stable until that edge; ready may
// depend combinationally on the other side's signals, valid never does.
interface mult12_accum_if
    import mult_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 5
) ();

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/mult12_accum.sv
// Register stage behind the combinational 12x12 multiplier: sums a frame of
// up to MAX_LEN products and holds the total, beat count and carry flag
// until the consumer takes them.
module mult12_accum
    import mult_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int MAX_LEN = 16,
    localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    mult12_accum_if.slave bus,
    output state_t        dbg_state
);

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ovf, ovf_n;
    logic             load_out;

    logic [ACC_W-1:0] out_sum_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_ovf_r;

    logic             accept;
    logic             close;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;

    // In HOLD a new beat is only taken when the result leaves in the same cycle.
    assign bus.in_ready = (state == HOLD) ? bus.out_ready : 1'b1;
    assign accept       = bus.in_valid && bus.in_ready;

    // acc/cnt/ovf are cleared on every close, so in HOLD they already hold
    // the fresh-frame base and an overlapping beat needs no special path.
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
    assign cnt_inc = cnt + 1'b1;
    assign ovf_inc = ovf | sum_ext[ACC_W];
    assign close   = bus.in_last || (cnt_inc == CNT_W'(MAX_LEN));

    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = out_sum_r;
    assign bus.out_count = out_count_r;
    assign bus.out_ovf   = out_ovf_r;
    assign dbg_state     = state;

    // Next-state and accumulator update for the frame FSM.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        ovf_n    = ovf;
        load_out = 1'b0;
        if (accept) begin
            if (close) begin
                state_n  = HOLD;
                acc_n    = '0;
                cnt_n    = '0;
                ovf_n    = 1'b0;
                load_out = 1'b1;
            end else begin
                state_n = ACC;
                acc_n   = sum_ext[ACC_W-1:0];
                cnt_n   = cnt_inc;
                ovf_n   = ovf_inc;
            end
        end else if ((state == HOLD) && bus.out_ready) begin
            state_n = IDLE;
        end
    end

    // State, accumulator and result registers; results load only on close.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_sum_r   <= '0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
            if (load_out) begin
                out_sum_r   <= sum_ext[ACC_W-1:0];
                out_count_r <= cnt_inc;
                out_ovf_r   <= ovf_inc;
            end
        end
    end

endmodule

// File: tb/tb_mult12_accum.sv
// Bench for mult12_accum: a 32-bit instance for the frame, backpressure and
// reset cases, and a 26-bit instance for carry-out behaviour.
module tb_mult12_accum;
    import mult_pkg::*;

    localparam int CNT_W   = 5;
    localparam int MAX_LEN = 16;
    localparam int W       = 1 + CNT_W + 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sel   = 1'b0;

    // Clock generation.
    always #5 clk = ~clk;

    mult12_accum_if #(.ACC_W(32), .CNT_W(CNT_W)) bus_a ();
    mult12_accum_if #(.ACC_W(26), .CNT_W(CNT_W)) bus_b ();
    state_t dbg_a, dbg_b;

    mult12_accum #(.ACC_W(32), .MAX_LEN(MAX_LEN)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a.slave),
        .dbg_state (dbg_a)
    );

    mult12_accum #(.ACC_W(26), .MAX_LEN(MAX_LEN)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b.slave),
        .dbg_state (dbg_b)
    );

    // Outputs of whichever instance is under test.
    logic        act_ready, act_valid, act_ovf;
    logic [31:0] act_sum;
    logic [4:0]  act_count;
    assign act_ready = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign act_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign act_ovf   = sel ? bus_b.out_ovf   : bus_a.out_ovf;
    assign act_sum   = sel ? 32'(bus_b.out_sum) : bus_a.out_sum;
    assign act_count = sel ? bus_b.out_count : bus_a.out_count;

    // Scoreboard: {ovf, count, sum} per frame, in completion order.
    logic [W-1:0] exp_q[$];
    logic         m_hold;
    int           m_cnt;
    int           n_pass = 0;
    int           n_tot  = 0;

    typedef struct {
        logic [23:0] prod;
        int          n;
        logic        last;
        logic [31:0] sum;
        logic [4:0]  cnt;
        logic        ovf;
    } row_t;
    row_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic push_exp(input logic [31:0] sum, input logic [4:0] cnt, input logic ovf);
        exp_q.push_back({ovf, cnt, sum});
    endtask

    // One clock of stimulus on the selected instance; checks are taken at the
    // falling edge, before the rising edge that consumes the inputs.
    task automatic step(input logic v, input logic [23:0] p, input logic l, input logic r);
        logic         exp_ready;
        logic [W-1:0] e;
        if (!sel) begin
            bus_a.in_valid = v; bus_a.in_prod = p; bus_a.in_last = l; bus_a.out_ready = r;
            bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        end else begin
            bus_b.in_valid = v; bus_b.in_prod = p; bus_b.in_last = l; bus_b.out_ready = r;
            bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        end
        @(negedge clk);
        exp_ready = m_hold ? r : 1'b1;
        chk("in_ready", 32'(act_ready), 32'(exp_ready));
        chk("out_valid", 32'(act_valid), 32'(m_hold));
        if (m_hold) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_has_entry", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q[0];
                chk("out_sum", act_sum, e[31:0]);
                chk("out_count", 32'(act_count), 32'(e[36:32]));
                chk("out_ovf", 32'(act_ovf), 32'(e[37]));
                if (r) void'(exp_q.pop_front());
            end
            if (r) m_hold = 1'b0;
        end
        if (v && exp_ready) begin
            m_cnt++;
            if (l || m_cnt == MAX_LEN) begin
                m_hold = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_hold = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    // Main test sequence.
    initial begin
        m_hold = 1'b0;
        m_cnt  = 0;
        bus_a.in_valid = 1'b0; bus_a.in_prod = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_prod = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b0;

        tbl[0] = '{24'hFFE001, 3,  1'b1, 32'h02FFA003, 5'd3,  1'b0};
        tbl[1] = '{24'h000005, 1,  1'b1, 32'd5,        5'd1,  1'b0};
        tbl[2] = '{24'h000000, 4,  1'b1, 32'd0,        5'd4,  1'b0};
        tbl[3] = '{24'hFFE001, 16, 1'b0, 32'h0FFE0010, 5'd16, 1'b0};
        tbl[4] = '{24'h000001, 16, 1'b0, 32'd16,       5'd16, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_a_sum",   bus_a.out_sum, 32'd0);
        chk("rst_a_count", 32'(bus_a.out_count), 32'd0);
        chk("rst_a_ovf",   32'(bus_a.out_ovf), 32'd0);
        chk("rst_a_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst_a_state", 32'(dbg_a), 32'(IDLE));
        chk("rst_b_valid", 32'(bus_b.out_valid), 32'd0);
        chk("rst_b_sum",   32'(bus_b.out_sum), 32'd0);
        chk("rst_b_ready", 32'(bus_b.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Table frames, with random stall length and ignored out_ready.
        for (int r = 0; r < 5; r++) begin
            push_exp(tbl[r].sum, tbl[r].cnt, tbl[r].ovf);
            for (int i = 0; i < tbl[r].n; i++)
                step(1'b1, tbl[r].prod, tbl[r].last && (i == tbl[r].n - 1),
                     1'($urandom_range(0, 1)));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                step(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 24'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Auto-close, stall with a pending beat, then overlapping handshakes.
        push_exp(32'd16, 5'd16, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 24'd1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 24'd7, 1'b0, 1'b0);
        push_exp(32'd10, 5'd2, 1'b0);
        step(1'b1, 24'd7, 1'b0, 1'b1);
        step(1'b1, 24'd3, 1'b1, 1'b0);
        step(1'b0, 24'd0, 1'b0, 1'b1);

        // Reset in the middle of a frame discards it.
        step(1'b1, 24'd9, 1'b0, 1'b0);
        step(1'b1, 24'd4, 1'b0, 1'b0);
        pulse_reset();
        step(1'b0, 24'd0, 1'b0, 1'b1);
        step(1'b0, 24'd0, 1'b1, 1'b0);
        push_exp(32'd5, 5'd1, 1'b0);
        step(1'b1, 24'd5, 1'b1, 1'b0);
        step(1'b0, 24'd0, 1'b0, 1'b1);

        // 26-bit accumulator: carry out, sticky flag cleared for next frame.
        sel = 1'b1;
        push_exp(32'd16736261, 5'd5, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 24'hFFE001, i == 4, 1'b0);
        step(1'b0, 24'd0, 1'b0, 1'b1);
        push_exp(32'd2, 5'd2, 1'b0);
        step(1'b1, 24'd1, 1'b0, 1'b0);
        step(1'b1, 24'd1, 1'b1, 1'b0);
        step(1'b0, 24'd0, 1'b0, 1'b0);
        // Release coincides with a one-beat frame: straight back to HOLD.
        push_exp(32'd9, 5'd1, 1'b0);
        step(1'b1, 24'd9, 1'b1, 1'b1);
        step(1'b0, 24'd0, 1'b0, 1'b1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
